// File: rtl/param_dual_port_ram.sv
// True dual-port byte-lane RAM with selectable read-during-write behaviour,
// write-collision resolution, optional output pipeline and a saturating collision counter.
module param_dual_port_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int COLL_MODE  = 0,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en0,
    input  logic                               en1,
    input  logic                               we0,
    input  logic                               we1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be1,
    input  logic [ADDR_WIDTH-1:0]              addr0,
    input  logic [ADDR_WIDTH-1:0]              addr1,
    input  logic [DATA_WIDTH-1:0]              wdata0,
    input  logic [DATA_WIDTH-1:0]              wdata1,
    output logic [DATA_WIDTH-1:0]              rdata0,
    output logic [DATA_WIDTH-1:0]              rdata1,
    output logic                               rvalid0,
    output logic                               rvalid1,
    output logic                               coll,
    output logic [CNT_WIDTH-1:0]               coll_cnt
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    logic                  wr0_s;
    logic                  wr1_s;
    logic                  same_s;
    logic                  coll_s;
    logic [DATA_WIDTH-1:0] new0_s;
    logic [DATA_WIDTH-1:0] new1_s;
    logic [DATA_WIDTH-1:0] rd0_s;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rdata0_r;
    logic [DATA_WIDTH-1:0] rdata1_r;
    logic                  rvalid0_r;
    logic                  rvalid1_r;
    logic                  coll_r;
    logic [CNT_WIDTH-1:0]  coll_cnt_r;

    // Word as it will look after this cycle's writes; lanes hit by both ports follow COLL_MODE.
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic                  hit0,
        input logic                  hit1,
        input logic [NB-1:0]         b0,
        input logic [NB-1:0]         b1,
        input logic [DATA_WIDTH-1:0] d0,
        input logic [DATA_WIDTH-1:0] d1
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_w;
        for (int l = 0; l < NB; l++) begin
            if (hit0 && b0[l] && hit1 && b1[l]) begin
                case (COLL_MODE)
                    32'sd1:  w[l*BYTE_WIDTH +: BYTE_WIDTH] = d0[l*BYTE_WIDTH +: BYTE_WIDTH];
                    32'sd2:  w[l*BYTE_WIDTH +: BYTE_WIDTH] = d1[l*BYTE_WIDTH +: BYTE_WIDTH];
                    default: w[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{1'bx}};
                endcase
            end else if (hit0 && b0[l]) begin
                w[l*BYTE_WIDTH +: BYTE_WIDTH] = d0[l*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (hit1 && b1[l]) begin
                w[l*BYTE_WIDTH +: BYTE_WIDTH] = d1[l*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                w[l*BYTE_WIDTH +: BYTE_WIDTH] = old_w[l*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return w;
    endfunction

    // Write qualification, merged next words, collision detect and read-during-write select.
    always_comb begin
        wr0_s  = en0 & we0 & ~rst;
        wr1_s  = en1 & we1 & ~rst;
        same_s = (addr0 == addr1);
        new0_s = merge_word(mem_r[addr0], wr0_s, wr1_s & same_s, be0, be1, wdata0, wdata1);
        new1_s = merge_word(mem_r[addr1], wr0_s & same_s, wr1_s, be0, be1, wdata0, wdata1);
        coll_s = wr0_s & wr1_s & same_s & (|(be0 & be1));
        if (RDW_MODE == 32'sd1) begin
            rd0_s = new0_s;
            rd1_s = new1_s;
        end else begin
            rd0_s = mem_r[addr0];
            rd1_s = mem_r[addr1];
        end
    end

    // Storage array; contents intentionally survive reset. Same-address writes store identical words.
    always_ff @(posedge clk) begin
        if (wr0_s) begin
            mem_r[addr0] <= new0_s;
        end
        if (wr1_s) begin
            mem_r[addr1] <= new1_s;
        end
    end

    // First read stage; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= {DATA_WIDTH{1'b0}};
            rdata1_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rvalid0_r <= en0;
            rvalid1_r <= en1;
            if (en0) begin
                rdata0_r <= rd0_s;
            end
            if (en1) begin
                rdata1_r <= rd1_s;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Optional output stage; reset flushes anything still in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    rdata0  <= {DATA_WIDTH{1'b0}};
                    rdata1  <= {DATA_WIDTH{1'b0}};
                end else begin
                    rvalid0 <= rvalid0_r;
                    rvalid1 <= rvalid1_r;
                    if (rvalid0_r) begin
                        rdata0 <= rdata0_r;
                    end
                    if (rvalid1_r) begin
                        rdata1 <= rdata1_r;
                    end
                end
            end
        end else begin : g_no_out_reg
            assign rvalid0 = rvalid0_r;
            assign rvalid1 = rvalid1_r;
            assign rdata0  = rdata0_r;
            assign rdata1  = rdata1_r;
        end
    endgenerate

    // Collision pulse and saturating counter, both independent of the read pipeline depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            coll_r <= coll_s;
            if (coll_s && (coll_cnt_r != {CNT_WIDTH{1'b1}})) begin
                coll_cnt_r <= coll_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign coll     = coll_r;
    assign coll_cnt = coll_cnt_r;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Scoreboard bench: three RAM configurations share one directed stimulus stream;
// expected responses are queued per port and checked by a separate negedge monitor.
module tb_param_dual_port_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en0, en1, we0, we1;
    logic [1:0]  be0, be1;
    logic [3:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic        rv [6];
    logic [15:0] rd [6];
    logic        cl [3];
    logic [7:0]  cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int due; logic [15:0] d; logic [15:0] m; } exp_t;
    typedef struct { int due; int n; } cexp_t;
    exp_t  q  [6][$];
    cexp_t cq [3][$];

    // A: old-data reads, X on collision, no output reg, 8-bit counter
    param_dual_port_ram u_a (
        .clk(clk), .rst(rst), .en0(en0), .en1(en1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rdata0(rd[0]), .rdata1(rd[1]),
        .rvalid0(rv[0]), .rvalid1(rv[1]), .coll(cl[0]), .coll_cnt(cnt_a));

    // B: new-data reads, port 1 wins, output reg, 2-bit counter
    param_dual_port_ram #(.RDW_MODE(1), .COLL_MODE(2), .OUT_REG(1), .CNT_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .en0(en0), .en1(en1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rdata0(rd[2]), .rdata1(rd[3]),
        .rvalid0(rv[2]), .rvalid1(rv[3]), .coll(cl[1]), .coll_cnt(cnt_b));

    // C: new-data reads, port 0 wins, no output reg
    param_dual_port_ram #(.RDW_MODE(1), .COLL_MODE(1)) u_c (
        .clk(clk), .rst(rst), .en0(en0), .en1(en1), .we0(we0), .we1(we1),
        .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .rdata0(rd[4]), .rdata1(rd[5]),
        .rvalid0(rv[4]), .rvalid1(rv[5]), .coll(cl[2]), .coll_cnt(cnt_c));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] cnt_of(input int d);
        case (d)
            0:       return cnt_a;
            1:       return {6'b0, cnt_b};
            default: return cnt_c;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp, input logic [15:0] m);
        tests++;
        if (((act ^ exp) & m) != 16'h0) begin
            fails++;
            $display("FAIL %s: got %h expected %h (mask %h) cyc %0d", name, act, exp, m, cyc);
        end
    endtask

    task automatic p0(input logic we, input logic [1:0] be, input logic [3:0] a, input logic [15:0] d);
        en0 = 1'b1; we0 = we; be0 = be; addr0 = a; wdata0 = d;
    endtask

    task automatic p1(input logic we, input logic [1:0] be, input logic [3:0] a, input logic [15:0] d);
        en1 = 1'b1; we1 = we; be1 = be; addr1 = a; wdata1 = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en0 = 1'b0; en1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    // expected read for A (old-data, masked), B (latency 2), C
    task automatic ex3(input int port, input logic [15:0] da, input logic [15:0] ma,
                       input logic [15:0] db, input logic [15:0] dc);
        q[port].push_back('{cyc + 1, da, ma});
        q[2 + port].push_back('{cyc + 2, db, 16'hFFFF});
        q[4 + port].push_back('{cyc + 1, dc, 16'hFFFF});
    endtask

    task automatic cx(input int na, input int nb, input int nc);
        cq[0].push_back('{cyc + 1, na});
        cq[1].push_back('{cyc + 1, nb});
        cq[2].push_back('{cyc + 1, nc});
    endtask

    // Monitor: pops an expectation whenever a DUT presents rvalid or coll
    initial begin
        exp_t  e;
        cexp_t c;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (rv[i] === 1'b1) begin
                    tests++;
                    if (q[i].size() == 0) begin
                        fails++;
                        $display("FAIL rvalid_unexpected[%0d]: got 1 expected 0 cyc %0d", i, cyc);
                    end else begin
                        e = q[i].pop_front();
                        if (e.due != cyc) begin
                            fails++;
                            $display("FAIL latency[%0d]: got cyc %0d expected cyc %0d", i, cyc, e.due);
                        end
                        if (e.m != 16'h0) chk($sformatf("rdata[%0d]", i), rd[i], e.d, e.m);
                    end
                end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
                    tests++; fails++;
                    $display("FAIL rvalid_missing[%0d]: got 0 expected 1 cyc %0d", i, cyc);
                    void'(q[i].pop_front());
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (cl[d] === 1'b1) begin
                    tests++;
                    if (cq[d].size() == 0) begin
                        fails++;
                        $display("FAIL coll_unexpected[%0d]: got 1 expected 0 cyc %0d", d, cyc);
                    end else begin
                        c = cq[d].pop_front();
                        if (c.due != cyc) begin
                            fails++;
                            $display("FAIL coll_latency[%0d]: got cyc %0d expected cyc %0d", d, cyc, c.due);
                        end
                        chk($sformatf("coll_cnt[%0d]", d), {8'h0, cnt_of(d)}, c.n[15:0], 16'h00FF);
                    end
                end else if (cq[d].size() != 0 && cq[d][0].due <= cyc) begin
                    tests++; fails++;
                    $display("FAIL coll_missing[%0d]: got 0 expected 1 cyc %0d", d, cyc);
                    void'(cq[d].pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        be0 = 2'b00; be1 = 2'b00; addr0 = 4'h0; addr1 = 4'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_rdata0[%0d]", d), rd[2*d], 16'h0, 16'hFFFF);
            chk($sformatf("rst_rdata1[%0d]", d), rd[2*d+1], 16'h0, 16'hFFFF);
            chk($sformatf("rst_rvalid[%0d]", d), {14'h0, rv[2*d], rv[2*d+1]}, 16'h0, 16'hFFFF);
            chk($sformatf("rst_coll[%0d]", d), {7'h0, cl[d], cnt_of(d)}, 16'h0, 16'hFFFF);
        end
        rst = 1'b0;
        tick();

        // basic write then read
        p0(1'b1, 2'b11, 4'd3, 16'hA55A); ex3(0, 16'h0, 16'h0, 16'hA55A, 16'hA55A); tick();
        p0(1'b0, 2'b00, 4'd3, 16'h0);    ex3(0, 16'hA55A, 16'hFFFF, 16'hA55A, 16'hA55A); tick();

        // byte lanes
        p0(1'b1, 2'b11, 4'd5, 16'h1234); ex3(0, 16'h0, 16'h0, 16'h1234, 16'h1234); tick();
        p1(1'b1, 2'b01, 4'd5, 16'hFFEE); ex3(1, 16'h1234, 16'hFFFF, 16'h12EE, 16'h12EE); tick();
        p1(1'b0, 2'b00, 4'd5, 16'h0);    ex3(1, 16'h12EE, 16'hFFFF, 16'h12EE, 16'h12EE); tick();

        // cross-port read during write
        p0(1'b1, 2'b11, 4'd7, 16'h0001); ex3(0, 16'h0, 16'h0, 16'h0001, 16'h0001); tick();
        p0(1'b1, 2'b11, 4'd7, 16'h00FF); p1(1'b0, 2'b00, 4'd7, 16'h0);
        ex3(0, 16'h0001, 16'hFFFF, 16'h00FF, 16'h00FF);
        ex3(1, 16'h0001, 16'hFFFF, 16'h00FF, 16'h00FF); tick();
        p1(1'b0, 2'b00, 4'd7, 16'h0);    ex3(1, 16'h00FF, 16'hFFFF, 16'h00FF, 16'h00FF); tick();

        // collision on lane 1 at address 2
        p0(1'b1, 2'b11, 4'd2, 16'h1111); p1(1'b1, 2'b10, 4'd2, 16'h2222);
        ex3(0, 16'h0, 16'h0, 16'h2211, 16'h1111);
        ex3(1, 16'h0, 16'h0, 16'h2211, 16'h1111);
        cx(1, 1, 1); tick();
        p0(1'b0, 2'b00, 4'd2, 16'h0);    ex3(0, 16'h0011, 16'h00FF, 16'h2211, 16'h1111); tick();

        // same address, disjoint lanes: no collision, both written
        p0(1'b1, 2'b01, 4'd9, 16'h00AB); p1(1'b1, 2'b10, 4'd9, 16'hCD00);
        ex3(0, 16'h0, 16'h0, 16'hCDAB, 16'hCDAB);
        ex3(1, 16'h0, 16'h0, 16'hCDAB, 16'hCDAB); tick();
        p1(1'b0, 2'b00, 4'd9, 16'h0);    ex3(1, 16'hCDAB, 16'hFFFF, 16'hCDAB, 16'hCDAB); tick();

        // four more collisions: counter in B saturates at 3
        for (int k = 2; k <= 5; k++) begin
            p0(1'b1, 2'b11, 4'd2, 16'h1111); p1(1'b1, 2'b10, 4'd2, 16'h2222);
            ex3(0, 16'h0011, 16'h00FF, 16'h2211, 16'h1111);
            ex3(1, 16'h0011, 16'h00FF, 16'h2211, 16'h1111);
            cx(k, (k > 3) ? 3 : k, k); tick();
        end

        // address extremes
        p0(1'b1, 2'b11, 4'd15, 16'hBEEF); p1(1'b1, 2'b11, 4'd0, 16'h0F0F);
        ex3(0, 16'h0, 16'h0, 16'hBEEF, 16'hBEEF);
        ex3(1, 16'h0, 16'h0, 16'h0F0F, 16'h0F0F); tick();
        p0(1'b0, 2'b00, 4'd15, 16'h0); p1(1'b0, 2'b00, 4'd0, 16'h0);
        ex3(0, 16'hBEEF, 16'hFFFF, 16'hBEEF, 16'hBEEF);
        ex3(1, 16'h0F0F, 16'hFFFF, 16'h0F0F, 16'h0F0F); tick();

        // rdata holds while idle; counter values after five collisions
        tick(); tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("hold_rvalid0[%0d]", d), {15'h0, rv[2*d]}, 16'h0, 16'hFFFF);
            chk($sformatf("hold_rdata0[%0d]", d), rd[2*d], 16'hBEEF, 16'hFFFF);
        end
        chk("sat_cnt_a", {8'h0, cnt_a}, 16'd5, 16'hFFFF);
        chk("sat_cnt_b", {14'h0, cnt_b}, 16'd3, 16'hFFFF);

        // reset while a read is in flight; write during reset must be suppressed
        p0(1'b0, 2'b00, 4'd3, 16'h0);
        q[0].push_back('{cyc + 1, 16'hA55A, 16'hFFFF});
        q[4].push_back('{cyc + 1, 16'hA55A, 16'hFFFF});
        tick();
        rst = 1'b1; p1(1'b1, 2'b11, 4'd5, 16'h0000); tick();
        rst = 1'b0; tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_rdata0[%0d]", d), rd[2*d], 16'h0, 16'hFFFF);
            chk($sformatf("midrst_rvalid0[%0d]", d), {15'h0, rv[2*d]}, 16'h0, 16'hFFFF);
            chk($sformatf("midrst_cnt[%0d]", d), {8'h0, cnt_of(d)}, 16'h0, 16'hFFFF);
        end
        p0(1'b0, 2'b00, 4'd3, 16'h0); p1(1'b0, 2'b00, 4'd5, 16'h0);
        ex3(0, 16'hA55A, 16'hFFFF, 16'hA55A, 16'hA55A);
        ex3(1, 16'h12EE, 16'hFFFF, 16'h12EE, 16'h12EE); tick();
        tick(); tick(); tick(); tick();

        for (int i = 0; i < 6; i++) begin
            tests++;
            if (q[i].size() != 0) begin
                fails++;
                $display("FAIL drain[%0d]: got %0d pending reads expected 0", i, q[i].size());
            end
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (cq[d].size() != 0) begin
                fails++;
                $display("FAIL coll_drain[%0d]: got %0d pending pulses expected 0", d, cq[d].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 4, address bits per port (depth = 2**ADDR_WIDTH).
REQ-002 SHALL provide parameter DATA_WIDTH, default 16, word width.
REQ-003 SHALL provide parameter BYTE_WIDTH, default 8, lane width; DATA_WIDTH is an integer multiple; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL provide parameter RDW_MODE, default 0, read-during-write: 0 = old data, 1 = new (merged) data.
REQ-005 SHALL provide parameter COLL_MODE, default 0, write-collision policy: 0 = lane poisoned to X, 1 = port 0 wins, 2 = port 1 wins.
REQ-006 SHALL provide parameter OUT_REG, default 0, 1 adds an output pipeline register to both ports.
REQ-007 SHALL provide parameter CNT_WIDTH, default 8, collision counter width.
REQ-008 clk  input  1  single clock, all logic on rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 en0, en1  input  1 each  port access enable.
REQ-011 we0, we1  input  1 each  write enable, qualified by enN.
REQ-012 be0, be1  input  NB each  byte-lane write enables, qualified by weN.
REQ-013 addr0, addr1  input  ADDR_WIDTH each  port address.
REQ-014 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-015 rdata0, rdata1  output  DATA_WIDTH each  registered read data.
REQ-016 rvalid0, rvalid1  output  1 each  rdataN valid qualifier.
REQ-017 coll  output  1  one-cycle write-collision pulse.
REQ-018 coll_cnt  output  CNT_WIDTH  saturating collision count.

Function
REQ-019 Every enN cycle SHALL be a read of addrN; with weN it is also a write of lanes where beN=1.
REQ-020 Read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); rvalidN SHALL be enN delayed by the same latency.
REQ-021 rdataN SHALL hold its last value while rvalidN=0.
REQ-022 Same-port read-during-write: rdataN SHALL return pre-write word (RDW_MODE=0) or word with written lanes merged (RDW_MODE=1).
REQ-023 Cross-port read (port A reads address port B writes same cycle) SHALL follow RDW_MODE identically, per lane.
REQ-024 Collision SHALL be en0&en1&we0&we1&(addr0==addr1)&|(be0&be1).
REQ-025 On collision, non-overlapping lanes SHALL be written normally by their owning port.
REQ-026 On collision, overlapping lanes SHALL be X (COLL_MODE=0), wdata0 (1) or wdata1 (2).
REQ-027 RDW_MODE=1 reads of a collided word SHALL return the value REQ-025/026 store; RDW_MODE=0 returns the old word.
REQ-028 coll SHALL pulse high the cycle after a collision, independent of OUT_REG.
REQ-029 coll_cnt SHALL increment by 1 per collision and saturate at 2**CNT_WIDTH-1 (no wrap).
REQ-030 Same address, both writing, disjoint byte enables SHALL NOT count as collision; both lane sets written.
REQ-031 Address wrap: none; addresses are exactly ADDR_WIDTH bits, all 2**ADDR_WIDTH entries usable.

Reset
REQ-032 While rst=1 writes SHALL be suppressed and reads SHALL not launch.
REQ-033 Reset SHALL clear rdata0/1=0, rvalid0/1=0, coll=0, coll_cnt=0 and the OUT_REG stage, on the next rising edge.
REQ-034 Memory contents SHALL NOT be reset; reads in flight at rst are discarded (rvalid stays 0).

Verification
REQ-035 Defaults: write port0 addr 3 wdata 0xA55A be 2'b11; next cycle read addr 3 -> rdata0=0xA55A, rvalid0=1 one cycle later.
REQ-036 Byte lanes: mem[5]=0x1234, port1 write 0xFFEE be 2'b01 at 5, then read -> 0x12EE.
REQ-037 RDW: mem[7]=0x0001; port0 writes 0x00FF at 7 while port1 reads 7 -> rdata1=0x0001 (RDW_MODE=0), 0x00FF (RDW_MODE=1).
REQ-038 Collision: both write addr 2, p0 0x1111 be 11, p1 0x2222 be 10 -> word 0xXX11/0x1111/0x2211 for COLL_MODE 0/1/2; coll pulses once; coll_cnt=1.
REQ-039 Saturation: CNT_WIDTH=2, five collisions -> coll_cnt sequence 1,2,3,3,3.
REQ-040 Reset mid-op: OUT_REG=1, read issued, rst next cycle -> rvalid0 never asserts, rdata0=0, prior memory retained on later read.
